// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: fixed-latency backing store behind the cache controller.
// Ports: clk, reset (sync, active-high), read/write requests, address,
// data_in -> data_out (registered read data), busy (in flight), done (pulse).
module main_memory_ctrl #(
  parameter int memory_bits = 5,
  parameter int data_bits   = 8,
  parameter int latency     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read_signal_memory,
  input  logic                   write_signal_memory,
  input  logic [memory_bits-1:0] address,
  input  logic [data_bits-1:0]   data_in,
  output logic [data_bits-1:0]   data_out,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << memory_bits;
  localparam logic [3:0] CNT_INIT = 4'(latency - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   op_q, op_d;
  logic [memory_bits-1:0] addr_q, addr_d;
  logic [data_bits-1:0]   data_q, data_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [data_bits-1:0]   dout_q, dout_d;
  logic                   mem_we;

  logic [data_bits-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write has priority; a coincident read is dropped.
        if (write_signal_memory || read_signal_memory) begin
          op_d    = write_signal_memory;
          addr_d  = address;
          data_d  = data_in;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (op_q) mem_we = 1'b1;
          else      dout_d = mem_q[addr_q];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 4'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Array comes up holding its own index so reads are predictable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= data_bits'(i);
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign data_out = dout_q;
  assign busy     = (state_q == WAIT);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: directed checks of main_memory_ctrl
// at latency 3 (main), 1 and 15 (sweep).
module tb_main_memory_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd   [3];
  logic       wr   [3];
  logic [4:0] ad   [3];
  logic [7:0] di   [3];
  logic [7:0] dout [3];
  logic       bz   [3];
  logic       dn   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.memory_bits(5), .data_bits(8), .latency(3)) u3 (
    .clk(clk), .reset(reset),
    .read_signal_memory(rd[0]), .write_signal_memory(wr[0]),
    .address(ad[0]), .data_in(di[0]),
    .data_out(dout[0]), .busy(bz[0]), .done(dn[0])
  );

  main_memory_ctrl #(.memory_bits(5), .data_bits(8), .latency(1)) u1 (
    .clk(clk), .reset(reset),
    .read_signal_memory(rd[1]), .write_signal_memory(wr[1]),
    .address(ad[1]), .data_in(di[1]),
    .data_out(dout[1]), .busy(bz[1]), .done(dn[1])
  );

  main_memory_ctrl #(.memory_bits(5), .data_bits(8), .latency(15)) u15 (
    .clk(clk), .reset(reset),
    .read_signal_memory(rd[2]), .write_signal_memory(wr[2]),
    .address(ad[2]), .data_in(di[2]),
    .data_out(dout[2]), .busy(bz[2]), .done(dn[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request pulse; returns negedges from acceptance to done
  // and the number of busy cycles seen before done.
  task automatic txn(input int s, input logic r, input logic w,
                     input logic [4:0] a, input logic [7:0] d,
                     output int lat, output int nbusy);
    @(negedge clk);
    rd[s] = r; wr[s] = w; ad[s] = a; di[s] = d;
    @(negedge clk);
    rd[s] = 1'b0; wr[s] = 1'b0;
    lat = 1; nbusy = 0;
    while (!dn[s] && lat < 40) begin
      if (bz[s]) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic timing_chk(input int s, input string tag, input int l,
                            input int lat, input int nbusy);
    chk({tag, "_lat"}, lat, l + 1);
    chk({tag, "_busy_cycles"}, nbusy, l);
    chk({tag, "_busy_at_done"}, bz[s], 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, dn[s], 1'b0);
  endtask

  // Held read level: first done and spacing of the next one.
  task automatic held_chk(input int s, input string tag, input int l);
    int c = 0;
    int t1 = -1;
    int t2 = -1;
    @(negedge clk);
    rd[s] = 1'b1; ad[s] = 5'd6;
    while (c < 100 && t2 < 0) begin
      @(negedge clk);
      c++;
      if (dn[s]) begin
        if (t1 < 0) t1 = c;
        else        t2 = c;
      end
    end
    rd[s] = 1'b0;
    chk({tag, "_first_done"}, t1, l + 1);
    chk({tag, "_spacing"}, t2 - t1, l + 2);
    chk({tag, "_data"}, dout[s], 8'h06);
    repeat (3) @(negedge clk);
  endtask

  int lat, nb, ndone;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; di[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", bz[0], 1'b0);
    chk("rst_done", dn[0], 1'b0);
    chk("rst_dout", dout[0], 8'h00);
    reset = 1'b0;

    txn(0, 1'b1, 1'b0, 5'd5, 8'h00, lat, nb);
    chk("rd5_data", dout[0], 8'h05);
    timing_chk(0, "rd5", 3, lat, nb);

    txn(0, 1'b0, 1'b1, 5'd12, 8'hA7, lat, nb);
    chk("wr12_dout_kept", dout[0], 8'h05);
    timing_chk(0, "wr12", 3, lat, nb);
    txn(0, 1'b1, 1'b0, 5'd12, 8'h00, lat, nb);
    chk("rd12_data", dout[0], 8'hA7);
    txn(0, 1'b1, 1'b0, 5'd11, 8'h00, lat, nb);
    chk("rd11_data", dout[0], 8'h0B);

    txn(0, 1'b1, 1'b1, 5'd3, 8'h5C, lat, nb);
    chk("both_dout_kept", dout[0], 8'h0B);
    chk("both_lat", lat, 4);
    txn(0, 1'b1, 1'b0, 5'd3, 8'h00, lat, nb);
    chk("rd3_data", dout[0], 8'h5C);

    @(negedge clk);
    rd[0] = 1'b1; ad[0] = 5'd2;
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 5'd9; di[0] = 8'hFF;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wr[0] = 1'b0;
      if (dn[0]) ndone++;
    end
    chk("wait_ign_data", dout[0], 8'h02);
    chk("wait_ign_ndone", ndone, 1);
    txn(0, 1'b1, 1'b0, 5'd2, 8'h00, lat, nb);
    chk("rd2_unchanged", dout[0], 8'h02);

    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 5'd7; di[0] = 8'h33;
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", bz[0], 1'b0);
    chk("midrst_done", dn[0], 1'b0);
    chk("midrst_dout", dout[0], 8'h00);
    txn(0, 1'b1, 1'b0, 5'd7, 8'h00, lat, nb);
    chk("rd7_after_rst", dout[0], 8'h07);

    txn(1, 1'b1, 1'b0, 5'd4, 8'h00, lat, nb);
    chk("l1_data", dout[1], 8'h04);
    timing_chk(1, "l1", 1, lat, nb);
    held_chk(1, "l1_held", 1);

    txn(2, 1'b1, 1'b0, 5'd20, 8'h00, lat, nb);
    chk("l15_data", dout[2], 8'h14);
    timing_chk(2, "l15", 15, lat, nb);
    held_chk(2, "l15_held", 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
